tr_flag_unit: RTL and testbench

//   Parametrised successor to the single-channel TR zero-flag logic.

---
 rtl/tr_flag_unit_if.sv | 34 +++
 rtl/tr_flag_unit.sv | 122 ++++++++++++
 tb/tb_tr_flag_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tr_flag_unit_if.sv
// Handshake/bus bundle for tr_flag_unit: producer result channels in,
// registered TR/flags and branch condition out.
interface tr_flag_unit_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH-1:0][WIDTH-1:0] in_result;
    logic [NUM_CH-1:0]            in_carry;
    logic [NUM_CH-1:0]            in_ovf;
    logic [3:0]                   flag_mask;
    logic                         sticky_clr;
    logic [2:0]                   cond;
    logic                         out_valid;
    logic                         out_ready;
    logic [WIDTH-1:0]             tr;
    logic                         tr_zf;
    logic                         tr_nf;
    logic                         tr_cf;
    logic                         tr_vf;
    logic                         sticky_vf;
    logic                         cond_true;

    modport master (
        output in_valid, in_result, in_carry, in_ovf, flag_mask, sticky_clr, cond, out_ready,
        input  in_ready, out_valid, tr, tr_zf, tr_nf, tr_cf, tr_vf, sticky_vf, cond_true
    );

    modport slave (
        input  in_valid, in_result, in_carry, in_ovf, flag_mask, sticky_clr, cond, out_ready,
        output in_ready, out_valid, tr, tr_zf, tr_nf, tr_cf, tr_vf, sticky_vf, cond_true
    );
endinterface

// File: rtl/tr_flag_unit.sv
// TR result register with ZF/NF/CF/VF derivation, sticky overflow and branch
// condition evaluation, fed by NUM_CH producers through a fixed/RR arbiter.
module tr_flag_unit #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2,
    parameter int ARB_RR = 0
) (
    input logic          clk_i,
    input logic          rst_n_i,
    tr_flag_unit_if.slave bus
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic vf;
        logic cf;
        logic nf;
        logic zf;
    } flags_t;

    flags_t            flg_q, flg_d, flg_new;
    logic [WIDTH-1:0]  tr_q, tr_d, res_g;
    logic              vld_q, vld_d;
    logic              sv_q, sv_d;
    logic [PW-1:0]     ptr_q, ptr_d, gnt;
    logic              gnt_vld, accept, capture;
    logic [NUM_CH-1:0] rdy;

    // Scan from the pointer downwards so the channel closest to it is kept last.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (ARB_RR != 0) ? int'(ptr_q) + k : k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (bus.in_valid[PW'(idx)]) begin
                gnt     = PW'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

    assign accept  = !vld_q | bus.out_ready;
    assign capture = accept & gnt_vld;
    assign res_g   = bus.in_result[gnt];

    always_comb begin
        rdy = '0;
        for (int g = 0; g < NUM_CH; g++)
            rdy[g] = capture & (gnt == PW'(g));
    end
    assign bus.in_ready = rdy;

    always_comb begin
        flg_new.vf = bus.in_ovf[gnt];
        flg_new.cf = bus.in_carry[gnt];
        flg_new.nf = res_g[WIDTH-1];
        flg_new.zf = (res_g == '0);
    end

    always_comb begin
        tr_d  = tr_q;
        flg_d = flg_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
        if (capture) begin
            tr_d  = res_g;
            flg_d = flags_t'((flg_new & bus.flag_mask) | (flg_q & ~bus.flag_mask));
            vld_d = 1'b1;
            if (ARB_RR != 0)
                ptr_d = (gnt == PW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
        end else if (accept) begin
            vld_d = 1'b0;
        end
    end

    // A fresh VF=1 capture outranks a same-cycle clear.
    always_comb begin
        sv_d = sv_q;
        if (capture && bus.flag_mask[3] && flg_new.vf) sv_d = 1'b1;
        else if (bus.sticky_clr)                        sv_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tr_q  <= '0;
            flg_q <= flags_t'(4'b0001);
            vld_q <= 1'b0;
            sv_q  <= 1'b0;
            ptr_q <= '0;
        end else begin
            tr_q  <= tr_d;
            flg_q <= flg_d;
            vld_q <= vld_d;
            sv_q  <= sv_d;
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        unique case (bus.cond)
            3'b000:  bus.cond_true = 1'b1;
            3'b001:  bus.cond_true = flg_q.zf;
            3'b010:  bus.cond_true = !flg_q.zf;
            3'b011:  bus.cond_true = flg_q.nf ^ flg_q.vf;
            3'b100:  bus.cond_true = !(flg_q.nf ^ flg_q.vf);
            3'b101:  bus.cond_true = flg_q.cf;
            3'b110:  bus.cond_true = !flg_q.cf;
            default: bus.cond_true = 1'b0;
        endcase
    end

    assign bus.out_valid = vld_q;
    assign bus.tr        = tr_q;
    assign bus.tr_zf     = flg_q.zf;
    assign bus.tr_nf     = flg_q.nf;
    assign bus.tr_cf     = flg_q.cf;
    assign bus.tr_vf     = flg_q.vf;
    assign bus.sticky_vf = sv_q;
endmodule

// File: tb/tb_tr_flag_unit.sv
// Bench for tr_flag_unit: a fixed-priority 2-channel and a round-robin
// 3-channel instance, checked every cycle against a behavioural model.
module tb_tr_flag_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tr_flag_unit_if #(.WIDTH(W), .NUM_CH(2)) bf();
    tr_flag_unit_if #(.WIDTH(W), .NUM_CH(3)) br();

    tr_flag_unit #(.WIDTH(W), .NUM_CH(2), .ARB_RR(0)) u_fix (
        .clk_i(clk), .rst_n_i(rst_n), .bus(bf.slave));
    tr_flag_unit #(.WIDTH(W), .NUM_CH(3), .ARB_RR(1)) u_rr (
        .clk_i(clk), .rst_n_i(rst_n), .bus(br.slave));

    // stimulus per instance (index 0 = fixed, 1 = round-robin)
    logic         s_rst;
    logic [2:0]   s_valid[2], s_carry[2], s_ovf[2], s_cond[2];
    logic [W-1:0] s_res[2][3];
    logic [3:0]   s_mask[2];
    logic         s_clr[2], s_ordy[2];

    // model state; m_f is {VF,CF,NF,ZF}
    logic [W-1:0] m_tr[2];
    logic [3:0]   m_f[2];
    logic         m_sv[2], m_ov[2];
    int           m_ptr[2];

    int n_vec = 0;
    int n_err = 0;

    function automatic int nch(int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int grant(int d);
        for (int k = 0; k < nch(d); k++) begin
            int c;
            c = (d == 1) ? (m_ptr[d] + k) % nch(d) : k;
            if (s_valid[d][c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [2:0] exp_rdy(int d);
        int g;
        g = grant(d);
        if ((!m_ov[d] || s_ordy[d]) && g >= 0) return 3'(1 << g);
        return 3'b000;
    endfunction

    function automatic logic exp_ct(int d);
        logic zf, nf, cf, vf;
        {vf, cf, nf, zf} = m_f[d];
        case (s_cond[d])
            3'd0: return 1'b1;
            3'd1: return zf;
            3'd2: return !zf;
            3'd3: return nf != vf;
            3'd4: return nf == vf;
            3'd5: return cf;
            3'd6: return !cf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic mreset(int d);
        m_tr[d] = '0; m_f[d] = 4'b0001; m_sv[d] = 1'b0; m_ov[d] = 1'b0; m_ptr[d] = 0;
    endtask

    task automatic advance(int d);
        int g;
        logic acc, cap;
        logic [W-1:0] r;
        logic [3:0] nf;
        if (!s_rst) begin mreset(d); return; end
        g   = grant(d);
        acc = !m_ov[d] || s_ordy[d];
        cap = acc && (g >= 0);
        if (cap) begin
            r  = s_res[d][g];
            nf = {s_ovf[d][g], s_carry[d][g], r[W-1], r == '0};
            for (int b = 0; b < 4; b++) if (s_mask[d][b]) m_f[d][b] = nf[b];
            m_tr[d]  = r;
            m_ov[d]  = 1'b1;
            m_ptr[d] = (g + 1) % nch(d);
        end else if (acc) begin
            m_ov[d] = 1'b0;
        end
        if (cap && s_mask[d][3] && s_ovf[d][g]) m_sv[d] = 1'b1;
        else if (s_clr[d])                      m_sv[d] = 1'b0;
    endtask

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply();
        rst_n = s_rst;
        bf.in_valid = s_valid[0][1:0]; bf.in_carry = s_carry[0][1:0]; bf.in_ovf = s_ovf[0][1:0];
        for (int i = 0; i < 2; i++) bf.in_result[i] = s_res[0][i];
        bf.flag_mask = s_mask[0]; bf.sticky_clr = s_clr[0]; bf.cond = s_cond[0]; bf.out_ready = s_ordy[0];
        br.in_valid = s_valid[1]; br.in_carry = s_carry[1]; br.in_ovf = s_ovf[1];
        for (int i = 0; i < 3; i++) br.in_result[i] = s_res[1][i];
        br.flag_mask = s_mask[1]; br.sticky_clr = s_clr[1]; br.cond = s_cond[1]; br.out_ready = s_ordy[1];
    endtask

    task automatic check(int d);
        logic [2:0] rdy;
        logic [W-1:0] tr;
        logic [3:0] f;
        logic ov, sv, ct;
        if (d == 0) begin
            rdy = {1'b0, bf.in_ready}; ov = bf.out_valid; tr = bf.tr;
            f = {bf.tr_vf, bf.tr_cf, bf.tr_nf, bf.tr_zf}; sv = bf.sticky_vf; ct = bf.cond_true;
        end else begin
            rdy = br.in_ready; ov = br.out_valid; tr = br.tr;
            f = {br.tr_vf, br.tr_cf, br.tr_nf, br.tr_zf}; sv = br.sticky_vf; ct = br.cond_true;
        end
        chk($sformatf("d%0d in_ready", d),  W'(rdy), W'(exp_rdy(d)));
        chk($sformatf("d%0d out_valid", d), W'(ov),  W'(m_ov[d]));
        chk($sformatf("d%0d TR", d),        tr,      m_tr[d]);
        chk($sformatf("d%0d flags", d),     W'(f),   W'(m_f[d]));
        chk($sformatf("d%0d sticky", d),    W'(sv),  W'(m_sv[d]));
        chk($sformatf("d%0d cond_true", d), W'(ct),  W'(exp_ct(d)));
    endtask

    task automatic cyc();
        @(negedge clk);
        apply();
        if (!s_rst) begin mreset(0); mreset(1); end
        #1;
        check(0);
        check(1);
        advance(0);
        advance(1);
    endtask

    logic [2:0] exp5[4];

    initial begin
        s_rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d] = '0; s_carry[d] = '0; s_ovf[d] = '0; s_cond[d] = '0;
            s_mask[d] = 4'hF; s_clr[d] = 1'b0; s_ordy[d] = 1'b1;
            for (int i = 0; i < 3; i++) s_res[d][i] = '0;
            mreset(d);
        end
        apply();
        cyc(); cyc();

        // reset state
        s_rst = 1'b1; s_cond[0] = 3'b001;
        cyc();
        chk("rst TR", bf.tr, '0);
        chk("rst ZF", W'(bf.tr_zf), 1);
        chk("rst cond_true", W'(bf.cond_true), 1);
        chk("rst out_valid", W'(bf.out_valid), 0);

        // simple capture of 1
        s_valid[0] = 3'b001; s_res[0][0] = 32'h0000_0001;
        cyc();
        chk("cap1 in_ready", W'(bf.in_ready), 1);
        s_valid[0] = '0;
        cyc();
        chk("cap1 TR", bf.tr, 32'h1);
        chk("cap1 ZF", W'(bf.tr_zf), 0);
        chk("cap1 NF", W'(bf.tr_nf), 0);
        chk("cap1 out_valid", W'(bf.out_valid), 1);

        // masked VF, then unmasked, then sticky clear
        s_valid[0] = 3'b001; s_res[0][0] = 32'h8000_0000; s_ovf[0] = 3'b001; s_mask[0] = 4'b0111;
        cyc();
        s_valid[0] = '0;
        cyc();
        chk("mask NF", W'(bf.tr_nf), 1);
        chk("mask VF hold", W'(bf.tr_vf), 0);
        chk("mask sticky", W'(bf.sticky_vf), 0);
        s_valid[0] = 3'b001; s_mask[0] = 4'hF;
        cyc();
        s_valid[0] = '0;
        cyc();
        chk("full VF", W'(bf.tr_vf), 1);
        chk("full sticky", W'(bf.sticky_vf), 1);
        s_clr[0] = 1'b1;
        cyc();
        s_clr[0] = 1'b0; s_ovf[0] = '0;
        cyc();
        chk("sticky clr", W'(bf.sticky_vf), 0);

        // stall with both channels pending
        s_valid[0] = 3'b001; s_res[0][0] = 32'h5;
        cyc();
        s_valid[0] = 3'b011; s_res[0][0] = 32'hAAAA; s_res[0][1] = 32'hBBBB; s_ordy[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall in_ready", W'(bf.in_ready), 0);
            chk("stall TR", bf.tr, 32'h5);
        end
        s_ordy[0] = 1'b1;
        cyc();
        chk("unstall grant", W'(bf.in_ready), 1);
        s_valid[0] = '0;
        cyc();
        chk("unstall TR", bf.tr, 32'hAAAA);

        // round-robin alternation
        exp5[0] = 3'b001; exp5[1] = 3'b010; exp5[2] = 3'b001; exp5[3] = 3'b010;
        s_valid[1] = 3'b011; s_res[1][0] = 32'h100; s_res[1][1] = 32'h101;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr grant", W'(br.in_ready), W'(exp5[i]));
        end
        s_valid[1] = '0;

        // carry conditions
        s_valid[0] = 3'b001; s_res[0][0] = 32'h7; s_carry[0] = 3'b001; s_cond[0] = 3'b101;
        cyc();
        s_valid[0] = '0; s_carry[0] = '0;
        cyc();
        chk("ltu true", W'(bf.cond_true), 1);
        s_cond[0] = 3'b110;
        cyc();
        chk("geu false", W'(bf.cond_true), 0);

        // reset while stalled
        s_valid[0] = 3'b001; s_res[0][0] = 32'h9;
        cyc();
        s_ordy[0] = 1'b0;
        cyc();
        #2;
        s_rst = 1'b0; rst_n = 1'b0;
        mreset(0); mreset(1);
        #1;
        chk("rst mid out_valid", W'(bf.out_valid), 0);
        chk("rst mid TR", bf.tr, '0);
        chk("rst mid ZF", W'(bf.tr_zf), 1);
        cyc();
        s_rst = 1'b1;
        cyc();

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            for (int d = 0; d < 2; d++) begin
                s_valid[d] = 3'($urandom);
                s_carry[d] = 3'($urandom);
                s_ovf[d]   = 3'($urandom);
                s_mask[d]  = 4'($urandom);
                s_cond[d]  = 3'($urandom);
                s_clr[d]   = ($urandom_range(7) == 0);
                s_ordy[d]  = ($urandom_range(3) != 0);
                for (int i = 0; i < 3; i++) begin
                    case ($urandom_range(3))
                        0:       s_res[d][i] = '0;
                        1:       s_res[d][i] = 32'h8000_0000;
                        default: s_res[d][i] = $urandom;
                    endcase
                end
            end
            s_rst = ($urandom_range(150) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
